// File: rtl/threshold_calc.sv
// Tiled local-mean threshold generator: streams each TxT image tile in, then writes its mean to every pixel of that tile.
// Optional build macro THRESHOLD_ROUND_EN selects round-half-up for the mean instead of truncation.
module threshold_calc #(
    parameter int WIDTH_BITS  = 7,
    parameter int HEIGHT_BITS = 7,
    parameter int TILE_BITS   = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic [WIDTH_BITS-1:0]  oImageCol,
    output logic [HEIGHT_BITS-1:0] oImageRow,
    input  logic [7:0]             iImageData,
    output logic [WIDTH_BITS-1:0]  oThresholdCol,
    output logic [HEIGHT_BITS-1:0] oThresholdRow,
    output logic [7:0]             oThresholdData,
    output logic                   oThresholdWren,
    output logic                   finished
);

    localparam int PIX_BITS = 2 * TILE_BITS;
    localparam int SUM_BITS = 8 + PIX_BITS;

    localparam logic [WIDTH_BITS-1:0]  COL_STEP   = WIDTH_BITS'(1) << TILE_BITS;
    localparam logic [HEIGHT_BITS-1:0] ROW_STEP   = HEIGHT_BITS'(1) << TILE_BITS;
    localparam logic [WIDTH_BITS-1:0]  COL_LAST   = {WIDTH_BITS{1'b1}} << TILE_BITS;
    localparam logic [HEIGHT_BITS-1:0] ROW_LAST   = {HEIGHT_BITS{1'b1}} << TILE_BITS;
    localparam logic [SUM_BITS-1:0]    ROUND_HALF = SUM_BITS'(1) << (PIX_BITS - 1);

    typedef enum logic [1:0] {
        ACCUM,
        LAST,
        FILL,
        DONE
    } state_t;

    state_t                 r_state;
    logic [PIX_BITS-1:0]    r_pix;
    logic [WIDTH_BITS-1:0]  r_col_base;
    logic [HEIGHT_BITS-1:0] r_row_base;
    logic [SUM_BITS-1:0]    r_sum;
    logic [7:0]             r_mean;
    logic                   r_wren;
    logic                   r_finished;

    logic [TILE_BITS-1:0]   w_pix_col;
    logic [TILE_BITS-1:0]   w_pix_row;
    logic [WIDTH_BITS-1:0]  w_col;
    logic [HEIGHT_BITS-1:0] w_row;
    logic [SUM_BITS-1:0]    w_sum_next;
    logic [7:0]             w_mean_next;
    logic                   w_last_pix;
    logic                   w_last_tile;

    // Tile bases keep their low TILE_BITS at zero, so OR-ing the in-tile offset forms the address.
    assign w_pix_col   = r_pix[TILE_BITS-1:0];
    assign w_pix_row   = r_pix[PIX_BITS-1:TILE_BITS];
    assign w_col       = r_col_base | WIDTH_BITS'(w_pix_col);
    assign w_row       = r_row_base | HEIGHT_BITS'(w_pix_row);
    assign w_sum_next  = r_sum + SUM_BITS'(iImageData);
    assign w_last_pix  = (r_pix == '1);
    assign w_last_tile = (r_col_base == COL_LAST) && (r_row_base == ROW_LAST);

`ifdef THRESHOLD_ROUND_EN
    assign w_mean_next = 8'((w_sum_next + ROUND_HALF) >> PIX_BITS);
`else
    assign w_mean_next = 8'(w_sum_next >> PIX_BITS);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ACCUM;
            r_pix      <= '0;
            r_col_base <= '0;
            r_row_base <= '0;
            r_sum      <= '0;
            r_mean     <= '0;
            r_wren     <= 1'b0;
            r_finished <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    // Data returned this cycle belongs to the previous address; pixel 0 restarts the sum.
                    if (r_pix == PIX_BITS'(1)) begin
                        r_sum <= SUM_BITS'(iImageData);
                    end else if (r_pix != '0) begin
                        r_sum <= w_sum_next;
                    end
                    if (w_last_pix) begin
                        r_pix   <= '0;
                        r_state <= LAST;
                    end else begin
                        r_pix <= r_pix + PIX_BITS'(1);
                    end
                end
                LAST: begin
                    r_sum   <= w_sum_next;
                    r_mean  <= w_mean_next;
                    r_wren  <= 1'b1;
                    r_state <= FILL;
                end
                FILL: begin
                    if (w_last_pix) begin
                        r_pix  <= '0;
                        r_wren <= 1'b0;
                        if (w_last_tile) begin
                            r_finished <= 1'b1;
                            r_state    <= DONE;
                        end else begin
                            r_state    <= ACCUM;
                            r_col_base <= r_col_base + COL_STEP;
                            if (r_col_base == COL_LAST) begin
                                r_row_base <= r_row_base + ROW_STEP;
                            end
                        end
                    end else begin
                        r_pix <= r_pix + PIX_BITS'(1);
                    end
                end
                DONE: begin
                    r_wren     <= 1'b0;
                    r_finished <= 1'b1;
                end
                default: begin
                    r_state <= ACCUM;
                end
            endcase
        end
    end

    assign oImageCol      = w_col;
    assign oImageRow      = w_row;
    assign oThresholdCol  = w_col;
    assign oThresholdRow  = w_row;
    assign oThresholdData = r_mean;
    assign oThresholdWren = r_wren;
    assign finished       = r_finished;

endmodule

// File: tb/tb_threshold_calc.sv
// Bench for threshold_calc: default-size instance (full maps, mid-FILL reset) and a 4x4/2x2-tile instance.
module tb_threshold_calc;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Default-size instance
    logic       reset;
    logic [6:0] oImageCol, oImageRow, oThresholdCol, oThresholdRow;
    logic [7:0] iImageData, oThresholdData;
    logic       oThresholdWren, finished;

    threshold_calc #(.WIDTH_BITS(7), .HEIGHT_BITS(7), .TILE_BITS(3)) dut (
        .clock          (clock),
        .reset          (reset),
        .oImageCol      (oImageCol),
        .oImageRow      (oImageRow),
        .iImageData     (iImageData),
        .oThresholdCol  (oThresholdCol),
        .oThresholdRow  (oThresholdRow),
        .oThresholdData (oThresholdData),
        .oThresholdWren (oThresholdWren),
        .finished       (finished)
    );

    // Small instance: 4x4 image, 2x2 tiles
    logic       s_reset;
    logic [1:0] s_icol, s_irow, s_tcol, s_trow;
    logic [7:0] s_idata, s_tdata;
    logic       s_wren, s_fin;

    threshold_calc #(.WIDTH_BITS(2), .HEIGHT_BITS(2), .TILE_BITS(1)) dut_s (
        .clock          (clock),
        .reset          (s_reset),
        .oImageCol      (s_icol),
        .oImageRow      (s_irow),
        .iImageData     (s_idata),
        .oThresholdCol  (s_tcol),
        .oThresholdRow  (s_trow),
        .oThresholdData (s_tdata),
        .oThresholdWren (s_wren),
        .finished       (s_fin)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] img   [0:127][0:127];
    logic [7:0] wval  [0:127][0:127];
    int         wcnt  [0:127][0:127];
    int         tile_exp [0:255];
    int         pr, pc;

    logic [7:0] img_s  [0:3][0:3];
    logic [7:0] wval_s [0:3][0:3];
    int         wcnt_s [0:3][0:3];
    int         tile_exp_s [0:3];
    int         spr, spc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int mean_of(input int sum, input int sh);
`ifdef THRESHOLD_ROUND_EN
        return (sum + (1 << (sh - 1))) >> sh;
`else
        return sum >> sh;
`endif
    endfunction

    // Image memory answers one cycle after the address.
    task automatic tick_big();
        @(posedge clock);
        #1;
        iImageData = img[pr][pc];
        pr = int'(oImageRow);
        pc = int'(oImageCol);
    endtask

    task automatic tick_small();
        @(posedge clock);
        #1;
        s_idata = img_s[spr][spc];
        spr = int'(s_irow);
        spc = int'(s_icol);
    endtask

    task automatic build_big(input bit patterned);
        for (int r = 0; r < 128; r++)
            for (int c = 0; c < 128; c++) begin
                int tile;
                int k;
                tile = (r / 8) * 16 + c / 8;
                k    = (r % 8) * 8 + c % 8;
                img[r][c] = 8'($urandom_range(0, 255));
                if (patterned) begin
                    if (tile == 0) img[r][c] = 8'(k);
                    if (tile == 1) img[r][c] = 8'd255;
                    if (tile == 2) img[r][c] = 8'd0;
                    if (tile == 3) img[r][c] = 8'd100;
                    if (tile == 4) img[r][c] = 8'(k < 32 ? 255 : 0);
                end
            end
        for (int tile = 0; tile < 256; tile++) begin
            int sum;
            sum = 0;
            for (int k = 0; k < 64; k++)
                sum += int'(img[(tile / 16) * 8 + k / 8][(tile % 16) * 8 + k % 8]);
            tile_exp[tile] = mean_of(sum, 6);
        end
    endtask

    task automatic run_big(input bit abort);
        int  n, t, tile, p, abort_n;
        bit  pending;
        pending = abort;
        abort_n = 5 * 129 + 65 + int'($urandom_range(0, 63));
        reset = 1'b1;
        repeat (3) tick_big();
        reset = 1'b0;
        for (int r = 0; r < 128; r++)
            for (int c = 0; c < 128; c++) wcnt[r][c] = 0;
        n = 0;
        while (n <= 33026) begin
            if (n < 33024) begin
                tile = n / 129;
                t    = n % 129;
                check("fin_low", 32'(finished), 0);
                check("wren", 32'(oThresholdWren), 32'(t >= 65));
                if (t < 64)
                    check("img_addr", 32'({oImageRow, oImageCol}),
                          32'((((tile / 16) * 8 + t / 8) << 7) | ((tile % 16) * 8 + t % 8)));
                if (t >= 65) begin
                    p = t - 65;
                    check("thr_addr", 32'({oThresholdRow, oThresholdCol}),
                          32'((((tile / 16) * 8 + p / 8) << 7) | ((tile % 16) * 8 + p % 8)));
                    check("thr_data", 32'(oThresholdData), 32'(tile_exp[tile]));
                end
            end else begin
                check("fin_high", 32'(finished), 1);
                check("wren_done", 32'(oThresholdWren), 0);
            end
            if (oThresholdWren === 1'b1) begin
                wcnt[oThresholdRow][oThresholdCol]++;
                wval[oThresholdRow][oThresholdCol] = oThresholdData;
            end
            if (pending && n == abort_n) begin
                pending = 1'b0;
                reset = 1'b1;
                tick_big();
                check("abort_wren", 32'(oThresholdWren), 0);
                check("abort_fin", 32'(finished), 0);
                check("abort_addr", 32'({oImageRow, oImageCol}), 0);
                tick_big();
                tick_big();
                reset = 1'b0;
                for (int r = 0; r < 128; r++)
                    for (int c = 0; c < 128; c++) wcnt[r][c] = 0;
                n = 0;
            end else begin
                tick_big();
                n++;
            end
        end
        for (int r = 0; r < 128; r++)
            for (int c = 0; c < 128; c++) begin
                check("map_cnt", 32'(wcnt[r][c]), 1);
                check("map_val", 32'(wval[r][c]), 32'(tile_exp[(r / 8) * 16 + c / 8]));
            end
    endtask

    task automatic run_small(input int mode);
        int n, t, tile, p;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                case (mode)
                    0:       img_s[r][c] = 8'(r * 4 + c);
                    1:       img_s[r][c] = 8'd255;
                    2:       img_s[r][c] = 8'd0;
                    default: img_s[r][c] = 8'($urandom_range(0, 255));
                endcase
                wcnt_s[r][c] = 0;
            end
        for (int k = 0; k < 4; k++) begin
            int sum;
            sum = 0;
            for (int q = 0; q < 4; q++)
                sum += int'(img_s[(k / 2) * 2 + q / 2][(k % 2) * 2 + q % 2]);
            tile_exp_s[k] = mean_of(sum, 2);
        end
        s_reset = 1'b1;
        repeat (2) tick_small();
        check("s_rst_wren", 32'(s_wren), 1'b0);
        check("s_rst_fin", 32'(s_fin), 1'b0);
        check("s_rst_addr", 32'({s_irow, s_icol}), 0);
        s_reset = 1'b0;
        for (n = 0; n <= 38; n++) begin
            if (n < 36) begin
                tile = n / 9;
                t    = n % 9;
                check("s_fin_low", 32'(s_fin), 0);
                check("s_wren", 32'(s_wren), 32'(t >= 5));
                if (t < 4)
                    check("s_img_addr", 32'({s_irow, s_icol}),
                          32'((((tile / 2) * 2 + t / 2) << 2) | ((tile % 2) * 2 + t % 2)));
                if (t >= 5) begin
                    p = t - 5;
                    check("s_thr_addr", 32'({s_trow, s_tcol}),
                          32'((((tile / 2) * 2 + p / 2) << 2) | ((tile % 2) * 2 + p % 2)));
                    check("s_thr_data", 32'(s_tdata), 32'(tile_exp_s[tile]));
                end
            end else begin
                check("s_fin_high", 32'(s_fin), 1);
                check("s_wren_done", 32'(s_wren), 0);
            end
            if (s_wren === 1'b1) begin
                wcnt_s[s_trow][s_tcol]++;
                wval_s[s_trow][s_tcol] = s_tdata;
            end
            tick_small();
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                check("s_map_cnt", 32'(wcnt_s[r][c]), 1);
                check("s_map_val", 32'(wval_s[r][c]), 32'(tile_exp_s[(r / 2) * 2 + c / 2]));
            end
    endtask

    initial begin
        reset      = 1'b1;
        s_reset    = 1'b1;
        iImageData = 8'd0;
        s_idata    = 8'd0;
        pr = 0; pc = 0; spr = 0; spc = 0;
        for (int r = 0; r < 128; r++)
            for (int c = 0; c < 128; c++) wval[r][c] = 8'd0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) wval_s[r][c] = 8'd0;

        for (int m = 0; m < 7; m++) run_small(m);
        s_reset = 1'b1;

        build_big(1'b1);
        run_big(1'b0);
        build_big(1'b0);
        run_big(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/threshold_calc.md
THRESHOLD_CALC -- requirements
Module: threshold_calc

Interface
REQ-001 SHALL have parameter WIDTH_BITS, default 7, image column address width; width = 2**WIDTH_BITS.
REQ-002 SHALL have parameter HEIGHT_BITS, default 7, image row address width; height = 2**HEIGHT_BITS.
REQ-003 SHALL have parameter TILE_BITS, default 3, tile side T = 2**TILE_BITS; legal range 1..min(WIDTH_BITS, HEIGHT_BITS).
REQ-004 SHALL have ports:
- clock  input  1  sole clock; all logic on posedge.
- reset  input  1  synchronous, active-high.
- oImageCol  output  WIDTH_BITS  image memory read column.
- oImageRow  output  HEIGHT_BITS  image memory read row.
- iImageData  input  8  image pixel; valid one cycle after its address.
- oThresholdCol  output  WIDTH_BITS  threshold memory write column.
- oThresholdRow  output  HEIGHT_BITS  threshold memory write row.
- oThresholdData  output  8  threshold value to write.
- oThresholdWren  output  1  threshold memory write enable.
- finished  output  1  whole threshold map written.

Function
REQ-005 SHALL partition the image into T x T tiles, processed in raster order (tile column fastest); pixels within a tile in raster order.
REQ-006 SHALL use FSM states ACCUM, LAST, FILL, DONE.
REQ-007 In ACCUM, SHALL present tile pixel k (k = 0..T*T-1) on oImageCol/oImageRow in cycle k, add iImageData of pixel k-1 to sum in cycle k for k >= 1, clear sum to the first pixel value in cycle 1, and go to LAST after k = T*T-1.
REQ-008 In LAST (1 cycle), SHALL add pixel T*T-1, load mean register from the completed sum, and go to FILL.
REQ-009 Sum SHALL be 8+2*TILE_BITS bits wide, unsigned, no overflow possible.
REQ-010 Mean SHALL be sum >> (2*TILE_BITS), truncated, 8 bits (rounding per REQ-019).
REQ-011 In FILL, SHALL assert oThresholdWren for exactly T*T consecutive cycles, writing the mean register to every pixel of the current tile in raster order, one address per cycle.
REQ-012 After FILL of a non-final tile, SHALL enter ACCUM of the next tile in the next cycle; after FILL of the final tile, SHALL enter DONE.
REQ-013 Each tile SHALL take exactly 2*T*T+1 cycles; no idle cycles between tiles.
REQ-014 oThresholdWren SHALL be 0 in ACCUM, LAST, DONE; threshold address/data are don't-care when Wren is 0.
REQ-015 In DONE, SHALL hold finished = 1, Wren = 0, until reset; no further memory traffic.
REQ-016 Addresses SHALL wrap only by tile advance; tile column wraps to 0 and tile row increments at image right edge.

Reset
REQ-017 While reset is high at a clock edge: state = ACCUM, tile = 0, pixel index = 0, sum = 0, mean = 0, oThresholdWren = 0, finished = 0; image address outputs = 0.
REQ-018 Reset asserted mid-operation (any state, including FILL) SHALL abort immediately, drop Wren on the next edge, and restart from tile 0 on the first cycle after reset deasserts; partially written tiles are not restored.

Configuration
REQ-019 Macro THRESHOLD_ROUND_EN: if defined, mean SHALL be (sum + 2**(2*TILE_BITS-1)) >> (2*TILE_BITS) (round half up, max 255, no saturation logic needed); if undefined, truncation per REQ-010. Timing is identical in both builds.

Verification
REQ-020 Constant image 100, defaults -> every threshold location written 100; finished rises exactly 33024 cycles after reset deassertion (256 tiles x 129).
REQ-021 All-255 image -> all thresholds 255 in both builds; all-0 image -> all 0.
REQ-022 Tile 0 holds pixels 0..63 with value = index, others 0, defaults -> tile 0 threshold 31 without macro, 32 with THRESHOLD_ROUND_EN (sum 2016); other tiles 0.
REQ-023 Write-stream check: per tile exactly 64 Wren cycles, each address written exactly once over the run, Wren never high during ACCUM/LAST, first Wren in cycle 65 of tile 0.
REQ-024 Reset asserted during tile 5 FILL, released 3 cycles later -> Wren 0 on the next edge, restart at tile 0 pixel (0,0), full correct map, finished 33024 cycles after release.
REQ-025 TILE_BITS=1, WIDTH_BITS=HEIGHT_BITS=2, image 0..15 raster -> tile means (truncated) 2, 4, 10, 12; finished after 36 cycles.
